// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with ready-handshake memory and bounded wait
module mips_multicycle_ctrl #(
  parameter int FUNCT_W  = 6,
  parameter int MAX_WAIT = 15,
  parameter bit ENABLE_J = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [FUNCT_W-1:0] alu_ctrl,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               instr_done,
  output logic               illegal,
  output logic               mem_err,
  output logic [3:0]         state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, RWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, ADDI_EX, ADDI_WB, JUMP
  } state_t;
  localparam logic [FUNCT_W-1:0] ALU_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] ALU_SUB = FUNCT_W'(6'b100010);
  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
  state_t st, nxt;
  logic [7:0] cnt;
  logic [5:0] op;
  logic mem_st, tmo, hold, unused_bits;
  assign op = instr[31:26];
  assign unused_bits = ^instr[25:FUNCT_W];
  // the wait counter restarts on every state entry, including FETCH re-entered after a timeout
  assign mem_st = st == FETCH || st == MEMRD || st == MEMWR;
  assign tmo = mem_st && !mem_ready && cnt == LAST;
  assign hold = mem_st && !mem_ready && !tmo;
  assign state = rst_n ? st : 4'd0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= FETCH;
      cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= hold ? cnt + 8'd1 : 8'd0;
    end
  always_comb begin
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_source = 2'd0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    alu_ctrl = '0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    instr_done = 1'b0;
    illegal = 1'b0;
    mem_err = 1'b0;
    nxt = FETCH;
    if (rst_n) begin
      case (st)
        FETCH: begin
          mem_read = 1'b1;
          alu_src_b = 2'd1;
          alu_ctrl = ALU_ADD;
          ir_write = mem_ready;
          pc_write = mem_ready;
          nxt = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_b = 2'd3;
          alu_ctrl = ALU_ADD;
          case (op)
            6'b000000: nxt = EXEC_R;
            6'b100011, 6'b101011: nxt = MEMADR;
            6'b000100, 6'b000101: nxt = BRANCH;
            6'b001000: nxt = ADDI_EX;
            6'b000010: nxt = ENABLE_J ? JUMP : FETCH;
            default: nxt = FETCH;
          endcase
          illegal = nxt == FETCH;
          instr_done = nxt == FETCH;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_ctrl = instr[FUNCT_W-1:0];
          nxt = RWB;
        end
        RWB: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
          instr_done = 1'b1;
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_ctrl = ALU_ADD;
          nxt = op == 6'b101011 ? MEMWR : MEMRD;
        end
        MEMRD: begin
          iord = 1'b1;
          mem_read = 1'b1;
          nxt = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          iord = 1'b1;
          mem_write = 1'b1;
          alu_ctrl = ALU_ADD;
          instr_done = mem_ready;
          nxt = mem_ready ? FETCH : MEMWR;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctrl = ALU_SUB;
          pc_source = 2'd1;
          pc_write = op[0] ? !zero : zero;
          instr_done = 1'b1;
        end
        ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_ctrl = ALU_ADD;
          nxt = ADDI_WB;
        end
        ADDI_WB: begin
          reg_write = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_source = 2'd2;
          pc_write = 1'b1;
          instr_done = 1'b1;
        end
        default: nxt = FETCH;
      endcase
      if (tmo) begin
        mem_err = 1'b1;
        instr_done = 1'b1;
        nxt = FETCH;
      end
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed and random instruction traces checked against a trace-building model
module tb_mips_multicycle_ctrl;
  localparam int MAXW = 15;
  localparam logic [21:0] IORD = 22'h1 << 21, MRD = 22'h1 << 20, MWR = 22'h1 << 19, IRW = 22'h1 << 18;
  localparam logic [21:0] PCW = 22'h1 << 17, PCS1 = 22'h1 << 15, PCS2 = 22'h2 << 15, ASA = 22'h1 << 14;
  localparam logic [21:0] B1 = 22'h1 << 12, B2 = 22'h2 << 12, B3 = 22'h3 << 12;
  localparam logic [21:0] ADD = 22'd32 << 6, SUB = 22'd34 << 6;
  localparam logic [21:0] RDST = 22'h20, M2R = 22'h10, RW = 22'h8, DONE = 22'h4, ILL = 22'h2, ERR = 22'h1;
  localparam logic [21:0] F = MRD | B1 | ADD, D = B3 | ADD;

  logic clk = 1'b0, rst_n, rst1, mem_ready, zero;
  logic [31:0] instr;
  logic iord0, mrd0, mwr0, irw0, pcw0, asa0, rdst0, m2r0, rw0, done0, ill0, err0;
  logic iord1, mrd1, mwr1, irw1, pcw1, asa1, rdst1, m2r1, rw1, done1, ill1, err1;
  logic [1:0] pcs0, asb0, pcs1, asb1;
  logic [5:0] alu0, alu1;
  logic [3:0] s0, s1;
  wire [21:0] o0 = {iord0, mrd0, mwr0, irw0, pcw0, pcs0, asa0, asb0, alu0, rdst0, m2r0, rw0, done0, ill0, err0};
  wire [21:0] o1 = {iord1, mrd1, mwr1, irw1, pcw1, pcs1, asa1, asb1, alu1, rdst1, m2r1, rw1, done1, ill1, err1};

  mips_multicycle_ctrl #(.FUNCT_W(6), .MAX_WAIT(MAXW), .ENABLE_J(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .iord(iord0), .mem_read(mrd0), .mem_write(mwr0), .ir_write(irw0), .pc_write(pcw0),
    .pc_source(pcs0), .alu_src_a(asa0), .alu_src_b(asb0), .alu_ctrl(alu0), .reg_dst(rdst0),
    .mem_to_reg(m2r0), .reg_write(rw0), .instr_done(done0), .illegal(ill0), .mem_err(err0), .state(s0));
  mips_multicycle_ctrl #(.FUNCT_W(6), .MAX_WAIT(MAXW), .ENABLE_J(1'b0)) u1 (
    .clk(clk), .rst_n(rst1), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .iord(iord1), .mem_read(mrd1), .mem_write(mwr1), .ir_write(irw1), .pc_write(pcw1),
    .pc_source(pcs1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_ctrl(alu1), .reg_dst(rdst1),
    .mem_to_reg(m2r1), .reg_write(rw1), .instr_done(done1), .illegal(ill1), .mem_err(err1), .state(s1));

  always #5 clk = ~clk;

  typedef struct {logic [21:0] v; int rdy; int z; bit f;} ent_t;
  ent_t q[$];
  int total = 0, bad = 0;
  bit sel = 1'b0;

  task automatic push(input logic [21:0] v, input int rdy, input int z, input bit f);
    q.push_back('{v, rdy, z, f});
  endtask

  // a memory phase of w not-ready cycles; w >= MAXW ends in a timeout cycle instead of completion
  task automatic mem_phase(input logic [21:0] v, input int w, input logic [21:0] on_rdy, input bit f, output bit ok);
    int n = w >= MAXW ? MAXW - 1 : w;
    for (int k = 0; k < n; k++) push(v, 0, 2, f);
    ok = w < MAXW;
    push(ok ? (v | on_rdy) : (v | DONE | ERR), ok ? 1 : 0, 2, f);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z, input int wf, input int wm, input bit jen);
    bit ok;
    mem_phase(F, wf, IRW | PCW, 1'b1, ok);
    if (!ok) return;
    if (op == 6'd0) begin
      push(D, 2, 2, 0); push(ASA | (22'(fn) << 6), 2, 2, 0); push(RW | RDST | DONE, 2, 2, 0);
    end else if (op == 6'd35) begin
      push(D, 2, 2, 0); push(ASA | B2 | ADD, 2, 2, 0);
      mem_phase(IORD | MRD, wm, 22'd0, 1'b0, ok);
      if (ok) push(RW | M2R | DONE, 2, 2, 0);
    end else if (op == 6'd43) begin
      push(D, 2, 2, 0); push(ASA | B2 | ADD, 2, 2, 0);
      mem_phase(IORD | MWR | ADD, wm, DONE, 1'b0, ok);
    end else if (op == 6'd4 || op == 6'd5) begin
      push(D, 2, 2, 0);
      push(ASA | SUB | PCS1 | DONE | (((op == 6'd4) ? z : !z) ? PCW : 22'd0), 2, int'(z), 0);
    end else if (op == 6'd8) begin
      push(D, 2, 2, 0); push(ASA | B2 | ADD, 2, 2, 0); push(RW | DONE, 2, 2, 0);
    end else if (op == 6'd2 && jen) begin
      push(D, 2, 2, 0); push(PCW | PCS2 | DONE, 2, 2, 0);
    end else push(D | ILL | DONE, 2, 2, 0);
  endtask

  task automatic check(input string tag, input logic [21:0] ev, input bit ef);
    logic [21:0] ov = sel ? o1 : o0;
    logic [3:0] os = sel ? s1 : s0;
    total++;
    assert (ov === ev) else begin
      bad++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, ov, ev);
    end
    total++;
    assert ((os == 4'd0) === ef) else begin
      bad++;
      $error("FAIL %s fetch_state observed=%0d expected=%0d", tag, os == 4'd0, ef);
    end
  endtask

  task automatic play(input string tag, input logic [31:0] ins, input int n);
    instr = ins;
    for (int i = 0; i < q.size() && (n < 0 || i < n); i++) begin
      mem_ready = q[i].rdy == 2 ? 1'($urandom) : 1'(q[i].rdy);
      zero = q[i].z == 2 ? 1'($urandom) : 1'(q[i].z);
      @(negedge clk);
      check(tag, q[i].v, q[i].f);
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'($urandom), fn};
  endfunction

  initial begin
    int wsel[8] = '{0, 0, 0, 1, 2, 3, 14, 15};
    logic [5:0] ops[7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd2};
    logic [5:0] op, fn;
    rst_n = 1'b0; rst1 = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    instr = {6'd0, 20'h12345, 6'b100000};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset", 22'd0, 1'b1);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    build(6'd0, 6'b100000, 1'b0, 0, 0, 1'b1); play("r_add", mk(6'd0, 6'b100000), -1);
    build(6'd35, 6'd0, 1'b0, 0, 3, 1'b1); play("lw_wait3", mk(6'd35, 6'd0), -1);
    build(6'd4, 6'd0, 1'b1, 0, 0, 1'b1); play("beq_z1", mk(6'd4, 6'd0), -1);
    build(6'd5, 6'd0, 1'b1, 0, 0, 1'b1); play("bne_z1", mk(6'd5, 6'd0), -1);
    build(6'd43, 6'd0, 1'b0, 0, 20, 1'b1); play("sw_timeout", mk(6'd43, 6'd0), -1);
    build(6'd43, 6'd0, 1'b0, 14, 14, 1'b1); play("sw_ready_last", mk(6'd43, 6'd0), -1);
    build(6'd8, 6'd0, 1'b0, 20, 0, 1'b1); play("fetch_timeout", mk(6'd8, 6'd0), -1);
    build(6'h3f, 6'd0, 1'b0, 0, 0, 1'b1); play("illegal_3f", mk(6'h3f, 6'd0), -1);
    build(6'd2, 6'd0, 1'b0, 1, 0, 1'b1); play("jump", mk(6'd2, 6'd0), -1);
    sel = 1'b1;
    @(negedge clk);
    check("nj_in_reset", 22'd0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; rst1 = 1'b1;
    build(6'd2, 6'd0, 1'b0, 0, 0, 1'b0); play("nj_jump_illegal", mk(6'd2, 6'd0), -1);
    build(6'd0, 6'b100010, 1'b0, 2, 0, 1'b0); play("nj_r_sub", mk(6'd0, 6'b100010), -1);
    rst1 = 1'b0; rst_n = 1'b1; sel = 1'b0;
    build(6'd35, 6'd0, 1'b0, 0, 0, 1'b1); play("lw_pre_reset", mk(6'd35, 6'd0), 4);
    rst_n = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("reset_in_memwb", 22'd0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    build(6'd0, 6'b100101, 1'b0, 0, 0, 1'b1); play("after_reset", mk(6'd0, 6'b100101), -1);
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 3) == 0 ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = 6'($urandom);
      build(op, fn, 1'($urandom), wsel[$urandom_range(0, 6)], wsel[$urandom_range(0, 7)], 1'b1);
      play("random", mk(op, fn), -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
